// File: rtl/agc_spi_pkg.sv
// Shared types and constants for the AGC SPI master and its SCLK generator.
package agc_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_DONE
  } state_e;

  localparam logic [1:0] CTRL_MODE_SPI = 2'b01;
  localparam int FRAME_BITS = 16;
  localparam int CMD_BITS   = 8;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);
  localparam logic [BIT_CNT_W-1:0] DATA_TOP = BIT_CNT_W'(CMD_BITS - 1);

  // Level driven on MOSI for frame bit idx (15..8 command, 7..0 data; data is 0 on reads).
  function automatic logic frame_bit(input logic [CMD_BITS-1:0]  cmd,
                                     input logic [CMD_BITS-1:0]  dat,
                                     input logic                 rd,
                                     input logic [BIT_CNT_W-1:0] idx);
    logic [2:0] pos;
    pos = idx[2:0];
    if (idx > DATA_TOP) return cmd[pos];
    return rd ? 1'b0 : dat[pos];
  endfunction

endpackage

// File: rtl/agc_spi_clk_gen.sv
// SCLK generator: toggles sclk every CLK_DIV cycles while en is high, idles low otherwise.
// rise_stb/fall_stb flag the cycle whose closing edge makes sclk rise/fall.
module agc_spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic main_clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          wrap;

  always_comb begin
    wrap   = (cnt_q == CW'(CLK_DIV - 1));
    cnt_d  = '0;
    sclk_d = 1'b0;
    if (en) begin
      cnt_d  = wrap ? '0 : cnt_q + 1'b1;
      sclk_d = wrap ? ~sclk_q : sclk_q;
    end
  end

  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk     = sclk_q;
  assign rise_stb = en & wrap & ~sclk_q;
  assign fall_stb = en & wrap & sclk_q;

endmodule

// File: rtl/agc_spi_master.sv
// SPI master for the AGC chip: one 16-bit frame (command, data) per accepted start edge; AGC_SPI_3WIRE_EN selects 3-wire SDIO.
// Trigger to done: 1+CSS_CYC+32*CLK_DIV+CSH_CYC cycles; no queuing, start edges while busy or disabled are dropped.
module agc_spi_master #(
  parameter int CLK_DIV = 4,
  parameter int CSS_CYC = 2,
  parameter int CSH_CYC = 2
) (
  input  logic       main_clk,
  input  logic       rst_n,
  input  logic       reg_reset,
  input  logic [1:0] control_mode,
  input  logic       start,
  input  logic [7:0] spi_mode,
  input  logic       channel,
  input  logic [7:0] spi_dataA,
  input  logic [7:0] spi_dataB,
  output logic [7:0] read_data,
  output logic       busy,
  output logic       done,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_mosi_oe,
  input  logic       spi_miso
);

  import agc_spi_pkg::*;

  state_e                 state_q, state_d;
  logic                   start_q, start_d;
  logic [CMD_BITS-1:0]    cmd_q, cmd_d;
  logic [CMD_BITS-1:0]    dat_q, dat_d;
  logic                   rd_q, rd_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]             tmr_q, tmr_d;
  logic [7:0]             rx_q, rx_d;
  logic [7:0]             read_data_q, read_data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   cs_n_q, cs_n_d;
  logic                   mosi_q, mosi_d;
  logic                   oe_q, oe_d;

  logic                   trigger;
  logic [BIT_CNT_W-1:0]   nxt_idx;
  logic                   shift_en;
  logic                   rise_stb, fall_stb;

  // Gating with reg_reset drops sclk low on the same edge that aborts the frame.
  assign shift_en = (state_q == ST_SHIFT) & ~reg_reset;

  agc_spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .main_clk (main_clk),
    .rst_n    (rst_n),
    .en       (shift_en),
    .sclk     (spi_sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_comb begin
    state_d     = state_q;
    start_d     = start;
    cmd_d       = cmd_q;
    dat_d       = dat_q;
    rd_d        = rd_q;
    bit_cnt_d   = bit_cnt_q;
    tmr_d       = tmr_q;
    rx_d        = rx_q;
    read_data_d = read_data_q;
    done_d      = 1'b0;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    oe_d        = oe_q;
    trigger     = start & ~start_q & (control_mode == CTRL_MODE_SPI) & (state_q == ST_IDLE);
    nxt_idx     = bit_cnt_q - 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d   = ST_CS_SETUP;
          cmd_d     = spi_mode;
          dat_d     = channel ? spi_dataB : spi_dataA;
          rd_d      = spi_mode[0];
          cs_n_d    = 1'b0;
          mosi_d    = spi_mode[7];
          tmr_d     = 8'(CSS_CYC - 1);
          bit_cnt_d = BIT_CNT_W'(FRAME_BITS - 1);
          rx_d      = '0;
        end
      end
      ST_CS_SETUP: begin
        if (tmr_q == 8'd0) state_d = ST_SHIFT;
        else               tmr_d   = tmr_q - 8'd1;
      end
      ST_SHIFT: begin
        if (rise_stb && rd_q && (bit_cnt_q <= DATA_TOP)) rx_d = {rx_q[6:0], spi_miso};
        if (fall_stb) begin
          if (bit_cnt_q == '0) begin
            state_d = ST_CS_HOLD;
            mosi_d  = 1'b0;
            oe_d    = 1'b1;
            tmr_d   = 8'(CSH_CYC - 1);
          end else begin
            bit_cnt_d = nxt_idx;
            mosi_d    = frame_bit(cmd_q, dat_q, rd_q, nxt_idx);
`ifdef AGC_SPI_3WIRE_EN
            // Release the shared SDIO pad for the whole read data phase.
            oe_d      = ~(rd_q && (nxt_idx <= DATA_TOP));
`else
            oe_d      = 1'b1;
`endif
          end
        end
      end
      ST_CS_HOLD: begin
        if (tmr_q == 8'd0) begin
          state_d = ST_DONE;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          if (rd_q) read_data_d = rx_q;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);

    // Soft reset aborts the frame but keeps the last byte read back.
    if (reg_reset) begin
      state_d   = ST_IDLE;
      cs_n_d    = 1'b1;
      mosi_d    = 1'b0;
      oe_d      = 1'b1;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      bit_cnt_d = '0;
      tmr_d     = '0;
    end
  end

  // start_q resets high so a level already asserted at reset release is not taken as an edge.
  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b1;
      cmd_q       <= '0;
      dat_q       <= '0;
      rd_q        <= 1'b0;
      bit_cnt_q   <= '0;
      tmr_q       <= '0;
      rx_q        <= '0;
      read_data_q <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      oe_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      cmd_q       <= cmd_d;
      dat_q       <= dat_d;
      rd_q        <= rd_d;
      bit_cnt_q   <= bit_cnt_d;
      tmr_q       <= tmr_d;
      rx_q        <= rx_d;
      read_data_q <= read_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
      oe_q        <= oe_d;
    end
  end

  assign read_data   = read_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign spi_cs_n    = cs_n_q;
  assign spi_mosi    = mosi_q;
  assign spi_mosi_oe = oe_q;

endmodule

// File: tb/tb_agc_spi_master.sv
// Scoreboard bench for agc_spi_master: stimulus pushes expected frames, a pin-level monitor checks them.
module tb_agc_spi_master;

  localparam int CLK_DIV = 4;
  localparam int CSS_CYC = 2;
  localparam int CSH_CYC = 2;
  localparam int LAT     = 1 + CSS_CYC + 32 * CLK_DIV + CSH_CYC;
`ifdef AGC_SPI_3WIRE_EN
  localparam bit W3 = 1'b1;
`else
  localparam bit W3 = 1'b0;
`endif

  logic       main_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       reg_reset = 1'b0;
  logic [1:0] control_mode = 2'b01;
  logic       start = 1'b0;
  logic [7:0] spi_mode = 8'h00;
  logic       channel = 1'b0;
  logic [7:0] spi_dataA = 8'h00;
  logic [7:0] spi_dataB = 8'h00;
  logic [7:0] read_data;
  logic       busy, done, spi_cs_n, spi_sclk, spi_mosi, spi_mosi_oe;
  logic       spi_miso;

  agc_spi_master #(.CLK_DIV(CLK_DIV), .CSS_CYC(CSS_CYC), .CSH_CYC(CSH_CYC)) dut (
    .main_clk(main_clk), .rst_n(rst_n), .reg_reset(reg_reset), .control_mode(control_mode),
    .start(start), .spi_mode(spi_mode), .channel(channel), .spi_dataA(spi_dataA),
    .spi_dataB(spi_dataB), .read_data(read_data), .busy(busy), .done(done),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_mosi_oe(spi_mosi_oe), .spi_miso(spi_miso)
  );

  always #5 main_clk = ~main_clk;

  int cyc = 0;
  always @(posedge main_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] bits;
    logic        rd;
    logic [7:0]  rdata;
    int          t0;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_rd = 8'h00;
  logic [7:0] miso_byte = 8'h00;

  // Monitor state, observed at the negative clock edge.
  int          mon_rises = 0;
  int          mon_falls = 0;
  int          oe_bad = 0;
  int          done_cnt = 0;
  logic [15:0] cap = '0;
  logic        prev_sclk = 1'b0;
  logic        prev_cs = 1'b1;
  logic        prev_done = 1'b0;

  // Chip model: presents the reply byte MSB first during the data-phase SCLK periods.
  always_comb begin
    spi_miso = 1'b0;
    if (mon_rises >= 8 && mon_rises < 16) spi_miso = miso_byte[15 - mon_rises];
  end

  always @(negedge main_clk) begin
    exp_t e;
    logic rd_now;
    logic oe_exp;
    rd_now = (exp_q.size() > 0) ? exp_q[0].rd : 1'b0;
    if (prev_cs && !spi_cs_n) begin
      mon_rises = 0;
      mon_falls = 0;
      cap = '0;
    end
    if (!spi_cs_n && spi_sclk && !prev_sclk) begin
      cap = {cap[14:0], spi_mosi};
      mon_rises++;
    end
    if (!spi_cs_n && !spi_sclk && prev_sclk) mon_falls++;
    oe_exp = (W3 && rd_now && !spi_cs_n && mon_falls >= 8 && mon_falls < 16) ? 1'b0 : 1'b1;
    if (spi_mosi_oe !== oe_exp) oe_bad++;
    if (done === 1'b1) begin
      done_cnt++;
      chk("done_pulse_width", 32'(prev_done), 32'd0);
      chk("done_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mosi_frame", 32'(cap), 32'(e.bits));
        chk("sclk_rises", mon_rises, 16);
        chk("read_data", 32'(read_data), 32'(e.rdata));
        chk("latency", cyc - e.t0, LAT);
        chk("mosi_oe_window", oe_bad, 0);
      end
    end
    prev_sclk = spi_sclk;
    prev_cs   = spi_cs_n;
    prev_done = done;
  end

  task automatic tick();
    @(negedge main_clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    chk("busy_release_in_time", 32'(n < 400), 32'd1);
  endtask

  task automatic do_frame(input logic [7:0] m, input logic ch, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] mb, input bit poke);
    exp_t e;
    miso_byte    = mb;
    control_mode = 2'b01;
    spi_mode     = m;
    channel      = ch;
    spi_dataA    = a;
    spi_dataB    = b;
    start        = 1'b1;
    e.bits  = {m, m[0] ? 8'h00 : (ch ? b : a)};
    e.rd    = m[0];
    e.rdata = m[0] ? mb : model_rd;
    e.t0    = cyc;
    if (m[0]) model_rd = mb;
    exp_q.push_back(e);
    tick();
    tick();
    // Frame is latched: scramble inputs to prove the shadow registers hold.
    spi_mode  = 8'($urandom);
    channel   = 1'($urandom);
    spi_dataA = 8'($urandom);
    spi_dataB = 8'($urandom);
    start     = 1'b0;
    if (poke) begin
      repeat (40) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    wait_idle();
    tick();
  endtask

  initial begin
    int bad;
    int n;
    int d0;
    start = 1'b1;
    repeat (3) @(posedge main_clk);
    #1 rst_n = 1'b1;
    tick();
    chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("rst_sclk", 32'(spi_sclk), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd0);
    chk("rst_mosi_oe", 32'(spi_mosi_oe), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_read_data", 32'(read_data), 32'h00);
    bad = 0;
    repeat (10) begin
      tick();
      if (busy !== 1'b0 || spi_cs_n !== 1'b1) bad++;
    end
    chk("no_edge_after_reset", bad, 0);
    start = 1'b0;
    tick();

    do_frame(8'hA4, 1'b0, 8'hF3, 8'h11, 8'h00, 1'b0);
    do_frame(8'hA5, 1'b1, 8'h22, 8'h3C, 8'h5C, 1'b1);

    control_mode = 2'b10;
    tick();
    start = 1'b1;
    bad = 0;
    repeat (20) begin
      tick();
      if (spi_cs_n !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("mode_gate", bad, 0);
    start = 1'b0;
    control_mode = 2'b01;
    tick();

    // Abort a read frame at bit 9 with reg_reset; nothing is pushed for it.
    miso_byte = 8'hE7;
    spi_mode  = 8'h81;
    start     = 1'b1;
    tick();
    tick();
    start = 1'b0;
    n = 0;
    while (spi_cs_n !== 1'b0 && n < 50) begin tick(); n++; end
    while (mon_rises < 7 && n < 300) begin tick(); n++; end
    chk("abort_reached_bit9", mon_rises, 7);
    d0 = done_cnt;
    reg_reset = 1'b1;
    tick();
    reg_reset = 1'b0;
    chk("abort_cs_n", 32'(spi_cs_n), 32'd1);
    chk("abort_sclk", 32'(spi_sclk), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (150) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_read_data_hold", 32'(read_data), 32'(model_rd));

    for (int i = 0; i < 14; i++) begin
      do_frame(8'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 5)) tick();
    end

    wait_idle();
    repeat (10) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("mosi_oe_final", oe_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
